mux_tree_pipelined: RTL and testbench
=====================================

Name: mux_tree_pipelined

Overview:
- Parametrised N-to-1 selector built as a binary tree of 2:1 mux levels, one register stage per level.
- Optional output inversion is implemented as a final 2:1 mux choosing between the data and its complement.
- Valid/ready streaming interface with global stall; used wherever a wide, multi-channel select must meet timing.
- Generalises the single 1-bit mux cell to WIDTH bits, N channels, pipelining and an invert mode.

Parameters:
- WIDTH, 8, bit width of each channel.
- N, 4, number of input channels; must be a power of two, N >= 2.
- (derived) LEVELS = $clog2(N), tree depth and pipeline latency in cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- up_valid  input  1  input transaction valid.
- up_ready  output  1  block can accept a transaction this cycle.
- up_data  input  N*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- up_sel  input  LEVELS  channel index to forward.
- up_invert  input  1  1 = output the bitwise complement of the selected channel.
- down_valid  output  1  output transaction valid.
- down_ready  input  1  consumer accepts the output this cycle.
- down_data  output  WIDTH  selected (optionally inverted) channel.

Behaviour:
- Reset: on a clk edge with rst=1, every stage valid bit clears to 0; down_valid=0 and down_data=0. Data registers of internal stages need not reset. rst has priority over all other activity.
- Pipeline: LEVELS register stages.
  - Stage k (1..LEVELS) halves the candidate count using up_sel bit k-1 (LSB first).
  - Stage k carries the remaining sel bits, invert and valid forward.
  - Stage LEVELS also applies the invert mux: out = invert ? ~d : d.
- Advance condition: advance = !down_valid || down_ready.
  - When advance=1, all stages shift one position.
  - When advance=0, every stage holds: valid, data, sel and invert are frozen, and down_data is stable.
- up_ready = advance (combinational). A transfer occurs when up_valid && up_ready.
  - Stage 1 loads valid = up_valid on advance; its data loads only if up_valid=1.
- Stage data registers load only when advance=1 and the incoming stage valid=1. On bubbles, down_data keeps its previous value.
- Latency: a transfer accepted at edge t appears at down_valid/down_data after edge t+LEVELS-1, provided there is no stall. Throughput is 1 per cycle.
- Bubbles are not collapsed. A stall freezes the whole pipe, including bubbles (simple global enable).
- Ordering: strictly in order; no loss or duplication under any down_ready pattern.
- Simultaneous input accept and output drain in the same cycle is legal and required at full rate.
- Reset mid-stream discards all in-flight items; none appear after rst deasserts.
- up_data, up_sel and up_invert are don't-care when up_valid=0.
- N=2 is legal: LEVELS=1, the invert mux sits in the single stage, latency 1.

Test Plan (WIDTH=8, N=4, LEVELS=2 unless stated):
- Reset: rst=1 for 2 cycles with up_valid=1, down_ready=1 -> down_valid=0 and down_data=8'h00 during reset and on the first cycle after deassertion.
- Select sweep: up_data={8'h44,8'h33,8'h22,8'h11} (ch3..ch0), up_sel=0,1,2,3 on consecutive cycles, up_invert=0, down_ready=1 -> down_data is 11,22,33,44 on 4 consecutive cycles, starting 2 cycles after the first accept, with down_valid=1 throughout.
- Invert: same data, up_sel=2, up_invert=1 -> down_data=8'hCC; then up_sel=0, up_invert=1 -> 8'hEE.
- Backpressure: stream sel=0,1,2,3; hold down_ready=0 for 3 cycles once down_valid=1 -> up_ready=0 and down_data held at 8'h11 during the stall. After release the outputs are 11,22,33,44 with no gaps, drops or duplicates.
- Bubbles: up_valid pattern 1,0,1,0 with sel 0,x,3,x -> down_valid pattern 1,0,1,0 lagging by 2 cycles, data 11,(held 11),44.
- Reset mid-stream: accept 2 items, assert rst for 1 cycle before either emerges -> down_valid stays 0 afterwards until new input is accepted; the new input emerges with normal latency.

Source files
------------

// File: rtl/mux_tree_pipelined_if.sv
// Streaming bundle for the pipelined N-to-1 select: upstream request with channel select
// and invert flag, downstream selected word; valid/ready on both sides.
interface mux_tree_pipelined_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int LEVELS = $clog2(N);

    logic                  up_valid;
    logic                  up_ready;
    logic [N*WIDTH-1:0]    up_data;
    logic [LEVELS-1:0]     up_sel;
    logic                  up_invert;
    logic                  down_valid;
    logic                  down_ready;
    logic [WIDTH-1:0]      down_data;

    modport master (
        output up_valid,
        output up_data,
        output up_sel,
        output up_invert,
        output down_ready,
        input  up_ready,
        input  down_valid,
        input  down_data
    );

    modport slave (
        input  up_valid,
        input  up_data,
        input  up_sel,
        input  up_invert,
        input  down_ready,
        output up_ready,
        output down_valid,
        output down_data
    );
endinterface

// File: rtl/mux_tree_pipelined.sv
// N-to-1 WIDTH-bit select as a binary tree of 2:1 mux levels, one register per level (latency LEVELS).
// Global-enable pipe: a stalled output freezes every stage, bubbles included; up_ready = !down_valid || down_ready.
module mux_tree_pipelined #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_tree_pipelined_if.slave   bus
);
    localparam int LEVELS   = $clog2(N);
    localparam int NODES    = N - 1;
    localparam int OUT_NODE = N - 2;

    if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
        $error("mux_tree_pipelined: N must be a power of two and at least 2");
    end

    // Stage k (1-based) keeps N>>k words packed in r_dat starting at this node index.
    function automatic int stage_base(input int k);
        return N - (N >> (k - 1));
    endfunction

    logic [WIDTH-1:0]  w_src      [N];
    logic [WIDTH-1:0]  w_nxt_dat  [NODES];
    logic              w_in_vld   [LEVELS];
    logic              w_in_inv   [LEVELS];
    logic [LEVELS-1:0] w_in_sel   [LEVELS];
    logic [WIDTH-1:0]  w_lo;
    logic [WIDTH-1:0]  w_hi;
    logic [WIDTH-1:0]  w_pick;
    logic              w_advance;

    logic [WIDTH-1:0]  r_dat      [NODES];
    logic              r_vld      [LEVELS];
    logic              r_inv      [LEVELS];
    logic [LEVELS-1:0] r_sel      [LEVELS];

    assign w_advance      = !r_vld[LEVELS-1] || bus.down_ready;
    assign bus.up_ready   = w_advance;
    assign bus.down_valid = r_vld[LEVELS-1];
    assign bus.down_data  = r_dat[OUT_NODE];

    always_comb begin
        w_lo   = '0;
        w_hi   = '0;
        w_pick = '0;
        for (int c = 0; c < N; c++) begin
            w_src[c] = bus.up_data[c*WIDTH +: WIDTH];
        end
        for (int n = 0; n < NODES; n++) begin
            w_nxt_dat[n] = '0;
        end

        w_in_vld[0] = bus.up_valid;
        w_in_inv[0] = bus.up_invert;
        w_in_sel[0] = bus.up_sel;
        for (int s = 1; s < LEVELS; s++) begin
            w_in_vld[s] = r_vld[s-1];
            w_in_inv[s] = r_inv[s-1];
            w_in_sel[s] = r_sel[s-1];
        end

        // Each stage consumes bit 0 of the select it receives; the rest travels shifted down.
        for (int s = 0; s < LEVELS; s++) begin
            for (int j = 0; j < (N >> (s + 1)); j++) begin
                if (s == 0) begin
                    w_lo = w_src[2*j];
                    w_hi = w_src[2*j+1];
                end else begin
                    w_lo = r_dat[stage_base(s) + 2*j];
                    w_hi = r_dat[stage_base(s) + 2*j + 1];
                end
                w_pick = w_in_sel[s][0] ? w_hi : w_lo;
                if (s == LEVELS - 1) begin
                    w_pick = w_in_inv[s] ? ~w_pick : w_pick;
                end
                w_nxt_dat[stage_base(s + 1) + j] = w_pick;
            end
        end
    end

    // Only valid bits and the output word are reset; internal payload is qualified by valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LEVELS; s++) begin
                r_vld[s] <= 1'b0;
            end
            r_dat[OUT_NODE] <= '0;
        end else if (w_advance) begin
            for (int s = 0; s < LEVELS; s++) begin
                r_vld[s] <= w_in_vld[s];
                if (w_in_vld[s]) begin
                    r_sel[s] <= w_in_sel[s] >> 1;
                    r_inv[s] <= w_in_inv[s];
                    for (int j = 0; j < (N >> (s + 1)); j++) begin
                        r_dat[stage_base(s + 1) + j] <= w_nxt_dat[stage_base(s + 1) + j];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mux_tree_pipelined.sv
// Bench for mux_tree_pipelined (WIDTH=8, N=4): directed vector table, then random traffic
// against a transaction-level delay-line model.
module tb_mux_tree_pipelined;
    localparam int WIDTH  = 8;
    localparam int N      = 4;
    localparam int LEVELS = 2;
    localparam logic [31:0] D = 32'h44332211;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_tree_pipelined_if #(.WIDTH(WIDTH), .N(N)) bus ();
    mux_tree_pipelined #(.WIDTH(WIDTH), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit         rst;
        bit         vld;
        logic [1:0] sel;
        bit         inv;
        bit         dn_rdy;
        bit         exp_vld;
        logic [7:0] exp_dat;
        bit         exp_rdy;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model: LEVELS slots, slot LEVELS-1 is the output; values computed directly from the channel.
    bit         m_vld [LEVELS];
    logic [7:0] m_val [LEVELS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input bit r, input bit v, input logic [1:0] s, input bit i,
                           input bit dr, input bit ev, input logic [7:0] ed, input bit eu);
        vecs.push_back('{r, v, s, i, dr, ev, ed, eu});
    endtask

    task automatic drive(input bit r, input bit v, input logic [1:0] s, input bit i,
                         input logic [31:0] d, input bit dr);
        rst            = r;
        bus.up_valid   = v;
        bus.up_sel     = s;
        bus.up_invert  = i;
        bus.up_data    = d;
        bus.down_ready = dr;
    endtask

    function automatic void model_clock(input bit r, input bit v, input logic [1:0] s, input bit i,
                                        input logic [31:0] d, input bit dr);
        logic [7:0] ch;
        bit         adv;
        ch  = d[s*8 +: 8];
        adv = !m_vld[LEVELS-1] || dr;
        if (r) begin
            for (int k = 0; k < LEVELS; k++) m_vld[k] = 1'b0;
            m_val[LEVELS-1] = 8'h00;
        end else if (adv) begin
            for (int k = LEVELS - 1; k > 0; k--) begin
                if (m_vld[k-1]) m_val[k] = m_val[k-1];
                m_vld[k] = m_vld[k-1];
            end
            m_vld[0] = v;
            if (v) m_val[0] = i ? ~ch : ch;
        end
    endfunction

    initial begin
        bit         r, v, i, dr;
        logic [1:0] s;
        logic [31:0] d;

        //       rst vld sel inv rdy  exp_vld exp_dat exp_rdy
        add_vec(1, 1, 0, 0, 1, 0, 8'h00, 1);   // reset held
        add_vec(0, 0, 0, 0, 1, 0, 8'h00, 1);   // first cycle after reset
        add_vec(0, 1, 0, 0, 1, 0, 8'h00, 1);   // select sweep
        add_vec(0, 1, 1, 0, 1, 0, 8'h00, 1);
        add_vec(0, 1, 2, 0, 1, 1, 8'h11, 1);
        add_vec(0, 1, 3, 0, 1, 1, 8'h22, 1);
        add_vec(0, 0, 0, 0, 1, 1, 8'h33, 1);
        add_vec(0, 0, 0, 0, 1, 1, 8'h44, 1);
        add_vec(0, 0, 0, 0, 1, 0, 8'h44, 1);
        add_vec(0, 1, 2, 1, 1, 0, 8'h44, 1);   // invert
        add_vec(0, 1, 0, 1, 1, 0, 8'h44, 1);
        add_vec(0, 0, 0, 0, 1, 1, 8'hCC, 1);
        add_vec(0, 0, 0, 0, 1, 1, 8'hEE, 1);
        add_vec(0, 0, 0, 0, 1, 0, 8'hEE, 1);
        add_vec(0, 1, 0, 0, 1, 0, 8'hEE, 1);   // backpressure
        add_vec(0, 1, 1, 0, 1, 0, 8'hEE, 1);
        add_vec(0, 1, 2, 0, 0, 1, 8'h11, 0);
        add_vec(0, 1, 2, 0, 0, 1, 8'h11, 0);
        add_vec(0, 1, 2, 0, 0, 1, 8'h11, 0);
        add_vec(0, 1, 2, 0, 1, 1, 8'h11, 1);
        add_vec(0, 1, 3, 0, 1, 1, 8'h22, 1);
        add_vec(0, 0, 0, 0, 1, 1, 8'h33, 1);
        add_vec(0, 0, 0, 0, 1, 1, 8'h44, 1);
        add_vec(0, 0, 0, 0, 1, 0, 8'h44, 1);
        add_vec(0, 1, 0, 0, 1, 0, 8'h44, 1);   // bubbles
        add_vec(0, 0, 1, 0, 1, 0, 8'h44, 1);
        add_vec(0, 1, 3, 0, 1, 1, 8'h11, 1);
        add_vec(0, 0, 2, 0, 1, 0, 8'h11, 1);
        add_vec(0, 0, 0, 0, 1, 1, 8'h44, 1);
        add_vec(0, 0, 0, 0, 1, 0, 8'h44, 1);
        add_vec(0, 1, 1, 0, 1, 0, 8'h44, 1);   // reset mid-stream
        add_vec(1, 1, 2, 0, 1, 0, 8'h44, 1);
        add_vec(0, 0, 0, 0, 1, 0, 8'h00, 1);
        add_vec(0, 1, 3, 0, 1, 0, 8'h00, 1);
        add_vec(0, 0, 0, 0, 1, 0, 8'h00, 1);
        add_vec(0, 0, 0, 0, 1, 1, 8'h44, 1);
        add_vec(0, 0, 0, 0, 1, 0, 8'h44, 1);

        drive(1, 1, 0, 0, D, 1);
        @(posedge clk);
        #1;

        for (int n = 0; n < vecs.size(); n++) begin
            drive(vecs[n].rst, vecs[n].vld, vecs[n].sel, vecs[n].inv, D, vecs[n].dn_rdy);
            @(negedge clk);
            check($sformatf("vec%0d_down_valid", n), bus.down_valid, vecs[n].exp_vld);
            check($sformatf("vec%0d_down_data", n), bus.down_data, vecs[n].exp_dat);
            check($sformatf("vec%0d_up_ready", n), bus.up_ready, vecs[n].exp_rdy);
            @(posedge clk);
            #1;
        end

        drive(1, 0, 0, 0, 0, 1);
        model_clock(1, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;

        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 149) == 0);
            v  = ($urandom_range(0, 3) != 0);
            s  = 2'($urandom_range(0, 3));
            i  = 1'($urandom_range(0, 1));
            d  = $urandom;
            dr = (((c / 300) % 2) == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive(r, v, s, i, d, dr);
            @(negedge clk);
            check("rnd_down_valid", bus.down_valid, m_vld[LEVELS-1]);
            check("rnd_down_data", bus.down_data, m_val[LEVELS-1]);
            check("rnd_up_ready", bus.up_ready, !m_vld[LEVELS-1] || dr);
            model_clock(r, v, s, i, d, dr);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
